// File: rtl/gc_xy_inj_seq.sv
// Joybus XY-injection transaction sequencer: forwards console commands to the
// controller, waits for the response (with timeout), patches stick X/Y, replies.
module gc_xy_inj_seq #(
  parameter int unsigned TIMEOUT_CYC = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        console_cmd_done,
  input  logic [23:0] console_cmd,
  output logic        ctlr_tx_start,
  output logic [23:0] ctlr_tx_cmd,
  input  logic        ctlr_tx_busy,
  input  logic        ctlr_rsp_valid,
  input  logic [63:0] ctlr_rsp,
  input  logic [3:0]  ctlr_rsp_len,
  input  logic        inj_en,
  input  logic        inj_mode,
  input  logic [7:0]  inj_x,
  input  logic [7:0]  inj_y,
  output logic        cons_tx_start,
  output logic [63:0] cons_tx_data,
  output logic [3:0]  cons_tx_len,
  input  logic        cons_tx_busy,
  output logic        busy,
  output logic        timeout_err,
  output logic        cmd_dropped
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_TX_WAIT, S_RSP_WAIT, S_PATCH, S_REPLY, S_RPL_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_rsp;
  logic [3:0]    r_len;

  logic          w_inj;
  logic [7:0]    w_x;
  logic [7:0]    w_y;
  logic [63:0]   w_patched;

  // Stick byte plus signed offset, clamped to the unsigned byte range.
  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [7:0] off);
    logic [9:0] sum;
    sum = {2'b00, base} + {{2{off[7]}}, off};
    if (sum[9])      return '0;
    else if (sum[8]) return '1;
    else             return sum[7:0];
  endfunction

  always_comb begin
    w_inj     = inj_en && (ctlr_tx_cmd[23:16] == 8'h40) && (r_len == 4'd8);
    w_x       = inj_mode ? sat_add(r_rsp[47:40], inj_x) : inj_x;
    w_y       = inj_mode ? sat_add(r_rsp[39:32], inj_y) : inj_y;
    w_patched = w_inj ? {r_rsp[63:48], w_x, w_y, r_rsp[31:0]} : r_rsp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rsp         <= '0;
      r_len         <= '0;
      ctlr_tx_start <= 1'b0;
      ctlr_tx_cmd   <= '0;
      cons_tx_start <= 1'b0;
      cons_tx_data  <= '0;
      cons_tx_len   <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      cmd_dropped   <= 1'b0;
    end else begin
      ctlr_tx_start <= 1'b0;
      cons_tx_start <= 1'b0;
      timeout_err   <= 1'b0;
      cmd_dropped   <= console_cmd_done && (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (console_cmd_done) begin
            ctlr_tx_cmd   <= console_cmd;
            ctlr_tx_start <= 1'b1;
            busy          <= 1'b1;
            r_state       <= S_FWD;
          end
        end
        S_FWD: r_state <= S_TX_WAIT;
        S_TX_WAIT: begin
          if (!ctlr_tx_busy) begin
            r_cnt   <= '0;
            r_state <= S_RSP_WAIT;
          end
        end
        S_RSP_WAIT: begin
          // A response in the final counted cycle still takes priority.
          if (ctlr_rsp_valid) begin
            r_rsp   <= ctlr_rsp;
            r_len   <= ctlr_rsp_len;
            r_state <= S_PATCH;
          end else if (r_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PATCH: begin
          cons_tx_data  <= w_patched;
          cons_tx_len   <= r_len;
          cons_tx_start <= 1'b1;
          r_state       <= S_REPLY;
        end
        S_REPLY: r_state <= S_RPL_WAIT;
        S_RPL_WAIT: begin
          if (!cons_tx_busy) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gc_xy_inj_seq.sv
// Scoreboard bench for gc_xy_inj_seq: directed cases plus randomized transactions
// checked against a byte-level reference model of the reply.
module tb_gc_xy_inj_seq;

  localparam int T = 2500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        console_cmd_done = 1'b0;
  logic [23:0] console_cmd = '0;
  logic        ctlr_tx_start;
  logic [23:0] ctlr_tx_cmd;
  logic        ctlr_tx_busy = 1'b0;
  logic        ctlr_rsp_valid = 1'b0;
  logic [63:0] ctlr_rsp = '0;
  logic [3:0]  ctlr_rsp_len = '0;
  logic        inj_en = 1'b0;
  logic        inj_mode = 1'b0;
  logic [7:0]  inj_x = '0;
  logic [7:0]  inj_y = '0;
  logic        cons_tx_start;
  logic [63:0] cons_tx_data;
  logic [3:0]  cons_tx_len;
  logic        cons_tx_busy = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic        cmd_dropped;

  gc_xy_inj_seq #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .console_cmd_done(console_cmd_done), .console_cmd(console_cmd),
    .ctlr_tx_start(ctlr_tx_start), .ctlr_tx_cmd(ctlr_tx_cmd), .ctlr_tx_busy(ctlr_tx_busy),
    .ctlr_rsp_valid(ctlr_rsp_valid), .ctlr_rsp(ctlr_rsp), .ctlr_rsp_len(ctlr_rsp_len),
    .inj_en(inj_en), .inj_mode(inj_mode), .inj_x(inj_x), .inj_y(inj_y),
    .cons_tx_start(cons_tx_start), .cons_tx_data(cons_tx_data), .cons_tx_len(cons_tx_len),
    .cons_tx_busy(cons_tx_busy), .busy(busy), .timeout_err(timeout_err),
    .cmd_dropped(cmd_dropped)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] cmd; int cyc; } cmd_exp_t;
  typedef struct { logic [63:0] data; logic [3:0] len; int cyc; } rply_exp_t;

  cmd_exp_t  q_cmd[$];
  rply_exp_t q_rply[$];
  int        q_to[$];
  int        q_drop[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_start = 0;
  int tx_nb = 1, rx_nb = 1, tx_cnt = 0, rx_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: pulse with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Reference reply: stick bytes replaced or offset-and-clamped for 8-byte polls.
  function automatic logic [63:0] ref_reply(input logic [23:0] cmd, input logic [63:0] rsp,
                                            input int len, input bit en, input bit mode,
                                            input logic [7:0] ix, input logic [7:0] iy);
    logic [63:0] r;
    int x, y;
    r = rsp;
    if (!(en && cmd[23:16] == 8'h40 && len == 8)) return r;
    if (!mode) begin
      x = int'(ix);
      y = int'(iy);
    end else begin
      x = int'(rsp[47:40]) + int'($signed(ix));
      y = int'(rsp[39:32]) + int'($signed(iy));
      if (x < 0) x = 0;
      if (x > 255) x = 255;
      if (y < 0) y = 0;
      if (y > 255) y = 255;
    end
    r[47:40] = 8'(x);
    r[39:32] = 8'(y);
    return r;
  endfunction

  // Transmitter models: busy from the cycle after start for a programmable length.
  always @(negedge clk) begin
    if (!rst_n) begin
      ctlr_tx_busy = 1'b0; tx_cnt = 0;
      cons_tx_busy = 1'b0; rx_cnt = 0;
    end else begin
      if (ctlr_tx_start) begin
        ctlr_tx_busy = 1'b1; tx_cnt = tx_nb;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) ctlr_tx_busy = 1'b0;
      end
      if (cons_tx_start) begin
        cons_tx_busy = 1'b1; rx_cnt = rx_nb;
      end else if (rx_cnt > 0) begin
        rx_cnt--;
        if (rx_cnt == 0) cons_tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    cmd_exp_t  ec;
    rply_exp_t er;
    int        ed;
    if (rst_n) begin
      if (ctlr_tx_start) begin
        last_start = cyc;
        if (q_cmd.size() == 0) unexpected("ctlr_tx_start");
        else begin
          ec = q_cmd.pop_front();
          check("ctlr_tx_cmd", 64'(ctlr_tx_cmd), 64'(ec.cmd));
          check("fwd_latency", 64'(cyc - ec.cyc), 64'(1));
          check("busy_at_fwd", 64'(busy), 64'(1));
        end
      end
      if (cons_tx_start) begin
        if (q_rply.size() == 0) unexpected("cons_tx_start");
        else begin
          er = q_rply.pop_front();
          check("cons_tx_data", cons_tx_data, er.data);
          check("cons_tx_len", 64'(cons_tx_len), 64'(er.len));
          check("reply_latency", 64'(cyc - er.cyc), 64'(2));
        end
      end
      if (timeout_err) begin
        if (q_to.size() == 0) unexpected("timeout_err");
        else begin
          ed = q_to.pop_front();
          check("timeout_latency", 64'(cyc - last_start), 64'(ed));
        end
      end
      if (cmd_dropped) begin
        if (q_drop.size() == 0) unexpected("cmd_dropped");
        else begin
          ed = q_drop.pop_front();
          check("drop_latency", 64'(cyc - ed), 64'(1));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic txn(input logic [23:0] cmd, input logic [63:0] rsp, input int len,
                     input bit en, input bit mode, input logic [7:0] ix, input logic [7:0] iy,
                     input int nbt, input int nbr, input int rd, input bit drop, input bit tmo);
    rply_exp_t er;
    int k;
    inj_en = en; inj_mode = mode; inj_x = ix; inj_y = iy;
    tx_nb = nbt; rx_nb = nbr;
    step();
    console_cmd = cmd; console_cmd_done = 1'b1;
    q_cmd.push_back('{cmd: cmd, cyc: cyc});
    step();
    console_cmd_done = 1'b0;
    k = 0;
    while (ctlr_tx_busy && k < 100) begin step(); k++; end
    if (tmo) begin
      q_to.push_back(T + nbt + 1);
      k = 0;
      step();
      while (busy && k < T + 50) begin step(); k++; end
      check("busy_after_timeout", 64'(busy), 64'(0));
      return;
    end
    if (drop) begin
      step(); step();
      console_cmd = ~cmd; console_cmd_done = 1'b1;
      q_drop.push_back(cyc);
      step();
      console_cmd_done = 1'b0;
    end
    repeat (rd) step();
    step();
    ctlr_rsp = rsp; ctlr_rsp_len = 4'(len); ctlr_rsp_valid = 1'b1;
    er.data = ref_reply(cmd, rsp, len, en, mode, ix, iy);
    er.len  = 4'(len);
    er.cyc  = cyc;
    q_rply.push_back(er);
    step();
    ctlr_rsp_valid = 1'b0;
    k = 0;
    while (busy && k < 200) begin step(); k++; end
    check("busy_after_reply", 64'(busy), 64'(0));
    // Stray response while idle must be ignored.
    ctlr_rsp_valid = 1'b1;
    step();
    ctlr_rsp_valid = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctlr_tx_start"}, 64'(ctlr_tx_start), 64'(0));
    check({tag, "_ctlr_tx_cmd"},   64'(ctlr_tx_cmd),   64'(0));
    check({tag, "_cons_tx_start"}, 64'(cons_tx_start), 64'(0));
    check({tag, "_cons_tx_data"},  cons_tx_data,       64'(0));
    check({tag, "_cons_tx_len"},   64'(cons_tx_len),   64'(0));
    check({tag, "_busy"},          64'(busy),          64'(0));
    check({tag, "_timeout_err"},   64'(timeout_err),   64'(0));
    check({tag, "_cmd_dropped"},   64'(cmd_dropped),   64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] c;
    logic [63:0] r;
    int          l;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    txn(24'h400301, 64'h0080_8081_7F7F_0000, 8, 1'b0, 1'b0, 8'h20, 8'hE0, 2, 2, 0, 1'b0, 1'b0);
    txn(24'h400301, 64'h0080_8081_7F7F_0000, 8, 1'b1, 1'b0, 8'h20, 8'hE0, 1, 1, 1, 1'b0, 1'b0);
    txn(24'h400301, 64'h0080_F010_7F7F_0000, 8, 1'b1, 1'b1, 8'h7F, 8'h80, 3, 2, 0, 1'b0, 1'b0);
    txn(24'h400301, 64'h0080_8080_7F7F_0000, 8, 1'b1, 1'b1, 8'h10, 8'hF0, 1, 3, 2, 1'b0, 1'b0);
    txn(24'h000000, 64'h0900_0300_0000_0000, 3, 1'b1, 1'b0, 8'h20, 8'hE0, 2, 1, 0, 1'b0, 1'b0);
    txn(24'h400302, 64'h0180_7F80_8080_1234, 8, 1'b1, 1'b1, 8'h05, 8'hFB, 2, 2, 3, 1'b1, 1'b0);
    txn(24'h400300, 64'h0, 8, 1'b1, 1'b0, 8'h00, 8'h00, 2, 1, 0, 1'b0, 1'b1);
    txn(24'h400301, 64'h0080_0102_7F7F_0000, 8, 1'b1, 1'b1, 8'h80, 8'h7F, 1, 1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      c = $urandom;
      if ($urandom_range(1, 0) == 1) c[23:16] = 8'h40;
      r = {$urandom, $urandom};
      l = ($urandom_range(2, 0) == 0) ? int'($urandom_range(8, 1)) : 8;
      txn(c, r, l, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), int'($urandom_range(5, 0)),
          ($urandom_range(3, 0) == 0), 1'b0);
    end

    // Reset while the controller transmitter is still busy.
    tx_nb = 6;
    step();
    console_cmd = 24'h400301; console_cmd_done = 1'b1;
    q_cmd.push_back('{cmd: 24'h400301, cyc: cyc});
    step();
    console_cmd_done = 1'b0;
    step();
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();

    check("q_cmd_left",  64'(q_cmd.size()),  64'(0));
    check("q_rply_left", 64'(q_rply.size()), 64'(0));
    check("q_to_left",   64'(q_to.size()),   64'(0));
    check("q_drop_left", 64'(q_drop.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
